// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: sizing helpers shared by the tick scheduler and its channels
package tick_sched_pkg;
  // Channel-select width; a single channel still needs a 1-bit select field.
  function automatic int ch_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction
  // Prescaler ratio between the system clock and the base tick.
  function automatic int base_div(input int clk_hz, input int base_hz);
    return clk_hz / base_hz;
  endfunction
endpackage

// File: rtl/tick_channel.sv
// tick_channel: one programmable tick channel counting base ticks
//   clk, reset  system clock, synchronous active-high reset
//   base_tick   prescaler pulse
//   load        commit strobe: take period/enable, clear the counter
//   period      period in base ticks, 0 = never tick
//   enable      channel enable
//   tick        registered 1-cycle tick pulse
//   enabled     enable bit, showing the new value already in the commit cycle
module tick_channel #(
  parameter int PERIOD_W = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                base_tick,
  input  logic                load,
  input  logic [PERIOD_W-1:0] period,
  input  logic                enable,
  output logic                tick,
  output logic                enabled
);
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] r_period;
  logic                r_en;
  logic                r_tick;
  logic                w_active;
  logic                w_last;
  assign w_active = base_tick & r_en & (|r_period);
  // Only meaningful while w_active, so period-1 never wraps in use.
  assign w_last   = r_cnt == r_period - PERIOD_W'(1);
  // A load wins over a coincident base tick, which is dropped for this channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_period <= '0;
      r_en     <= 1'b0;
      r_tick   <= 1'b0;
    end else if (load) begin
      r_cnt    <= '0;
      r_period <= period;
      r_en     <= enable;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= w_active & w_last;
      if (w_active) r_cnt <= w_last ? '0 : r_cnt + PERIOD_W'(1);
    end
  end
  assign tick    = r_tick;
  assign enabled = load ? enable : r_en;
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared prescaler plus N_CH programmable tick-enable channels
//   clk, reset  system clock, synchronous active-high reset
//   cfg_valid   config write request       cfg_ready  write can be accepted
//   cfg_ch      target channel             cfg_period period in base ticks (0 = never)
//   cfg_enable  channel enable             cfg_err    pulse: committed write had bad channel
//   base_tick   1-cycle pulse at BASE_FREQ_HZ
//   ch_enabled  per-channel enable bit     tick       per-channel 1-cycle tick pulse
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter  int CLK_FREQ_HZ  = 100_000_000,
  parameter  int BASE_FREQ_HZ = 1_000_000,
  parameter  int N_CH         = 4,
  parameter  int PERIOD_W     = 20,
  localparam int CH_W         = ch_w(N_CH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cfg_enable,
  output logic                cfg_err,
  output logic                base_tick,
  output logic [N_CH-1:0]     ch_enabled,
  output logic [N_CH-1:0]     tick
);
  localparam int BASE_DIV = base_div(CLK_FREQ_HZ, BASE_FREQ_HZ);
  localparam int BC_W     = $clog2(BASE_DIV);
  typedef struct packed {
    logic [CH_W-1:0]     ch;
    logic [PERIOD_W-1:0] period;
    logic                enable;
  } cfg_wr_t;
  logic [BC_W-1:0] r_base_cnt;
  logic            r_base_tick;
  logic            r_commit;
  cfg_wr_t         r_cfg;
  logic            w_wrap;
  logic            w_accept;
  logic [N_CH-1:0] w_sel;
  assign w_wrap   = r_base_cnt == BC_W'(BASE_DIV - 1);
  assign w_accept = cfg_valid & ~r_commit;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base_cnt  <= '0;
      r_base_tick <= 1'b0;
    end else begin
      r_base_cnt  <= w_wrap ? '0 : r_base_cnt + BC_W'(1);
      r_base_tick <= w_wrap;
    end
  end
  // Accepted write is held for exactly one commit cycle, which also blocks the next accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_commit <= 1'b0;
      r_cfg    <= '0;
    end else begin
      r_commit <= w_accept;
      if (w_accept) r_cfg <= '{ch: cfg_ch, period: cfg_period, enable: cfg_enable};
    end
  end
  // Decoding against each real channel keeps the out-of-range test free of constant compares.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign w_sel[c] = r_cfg.ch == CH_W'(c);
    tick_channel #(.PERIOD_W(PERIOD_W)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .base_tick(r_base_tick),
      .load     (r_commit & w_sel[c]),
      .period   (r_cfg.period),
      .enable   (r_cfg.enable),
      .tick     (tick[c]),
      .enabled  (ch_enabled[c])
    );
  end
  assign cfg_ready = ~r_commit;
  assign cfg_err   = r_commit & ~(|w_sel);
  assign base_tick = r_base_tick;
endmodule
